// File: rtl/input_cond_pkg.sv
// Shared constants and sizing helpers for the input conditioner.
package input_cond_pkg;

  localparam int CLK_HZ      = 50000000;
  localparam int DEBOUNCE_MS = 20;

  function automatic int cycles_from_ms(input int ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

  // Counter width for a count that tops out at n-1; never narrower than 1 bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEFAULT_DEBOUNCE_CYCLES   = cycles_from_ms(DEBOUNCE_MS);
  localparam int DEFAULT_LONG_PRESS_CYCLES = 50000000;

endpackage

// File: rtl/debounce_cell.sv
// One input channel: two-flop synchronizer, counter debounce, registered edge pulses.
module debounce_cell
  import input_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic CLOCK_50,
  input  logic RESET_N,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int              CW   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          s;

  assign s = sync[1];

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], din};
      rise <= 1'b0;
      fall <= 1'b0;
      // Any agreement with the stable level restarts the qualification window.
      if (s == level) begin
        cnt <= '0;
      end else if (cnt == TERM) begin
        cnt   <= '0;
        level <= s;
        rise  <= s;
        fall  <= ~s;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Conditions raw KEY/SW inputs: sync, debounce, edge pulses, key toggles.
// Optional long-press detection is built when LONG_PRESS_EN is defined.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int N_KEYS            = 4,
  parameter int N_SW              = 10,
  parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic [N_KEYS-1:0] KEY,
  input  logic [N_SW-1:0]   SW,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_toggle,
  output logic [N_SW-1:0]   sw_level,
  output logic [N_SW-1:0]   sw_change,
  output logic [N_KEYS-1:0] key_long
);

  logic [N_SW-1:0]   sw_rise, sw_fall;
  logic [N_KEYS-1:0] tog_q;

  generate
    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
      // Keys are active-low on the board; invert before the synchronizer.
      debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cell (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .din      (~KEY[i]),
        .level    (key_level[i]),
        .rise     (key_press[i]),
        .fall     (key_release[i])
      );
    end
    for (genvar j = 0; j < N_SW; j++) begin : g_sw
      debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cell (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .din      (SW[j]),
        .level    (sw_level[j]),
        .rise     (sw_rise[j]),
        .fall     (sw_fall[j])
      );
    end
  endgenerate

  assign sw_change = sw_rise | sw_fall;

  // The press pulse is folded in so the visible toggle flips on the press edge itself.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) tog_q <= '0;
    else          tog_q <= tog_q ^ key_press;
  end

  assign key_toggle = tog_q ^ key_press;

`ifdef LONG_PRESS_EN
  localparam int              HW    = cnt_width(LONG_PRESS_CYCLES);
  localparam logic [HW-1:0]   HTERM = HW'(LONG_PRESS_CYCLES - 1);

  logic [N_KEYS-1:0][HW-1:0] hold;
  logic [N_KEYS-1:0]         fired;

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      hold     <= '0;
      fired    <= '0;
      key_long <= '0;
    end else begin
      for (int i = 0; i < N_KEYS; i++) begin
        key_long[i] <= 1'b0;
        if (!key_level[i]) begin
          hold[i]  <= '0;
          fired[i] <= 1'b0;
        end else if (hold[i] != HTERM) begin
          hold[i] <= hold[i] + 1'b1;
        end else if (!fired[i]) begin
          // Saturated counter plus fired flag gives one pulse per hold.
          key_long[i] <= 1'b1;
          fired[i]    <= 1'b1;
        end
      end
    end
  end
`else
  assign key_long = '0;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with a window-rule reference model.
module tb_input_conditioner;

  localparam int NK  = 4;
  localparam int NS  = 10;
  localparam int NC  = NK + NS;
  localparam int DEB = 4;
  localparam int LP  = 16;
`ifdef LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic          CLOCK_50 = 1'b0;
  logic          RESET_N;
  logic [NK-1:0] KEY;
  logic [NS-1:0] SW;
  logic [NK-1:0] key_level, key_press, key_release, key_toggle, key_long;
  logic [NS-1:0] sw_level, sw_change;

  int checks = 0;
  int errors = 0;

  input_conditioner #(
    .N_KEYS(NK), .N_SW(NS), .DEBOUNCE_CYCLES(DEB), .LONG_PRESS_CYCLES(LP)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .RESET_N     (RESET_N),
    .KEY         (KEY),
    .SW          (SW),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .key_toggle  (key_toggle),
    .sw_level    (sw_level),
    .sw_change   (sw_change),
    .key_long    (key_long)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a channel's level takes value v once the last DEB synchronized
  // samples all equal v and v differs from the current level.
  logic [NC-1:0] m_s1, m_s2, m_lvl, m_rise, m_fall, din;
  logic [NC-1:0] m_hist [DEB];
  logic [NK-1:0] m_tog, m_long;
  int            m_held [NK];

  initial begin
    m_s1 = '0; m_s2 = '0; m_lvl = '0; m_rise = '0; m_fall = '0;
    m_tog = '0; m_long = '0;
    for (int k = 0; k < DEB; k++) m_hist[k] = '0;
    for (int k = 0; k < NK; k++) m_held[k] = 0;
    forever begin
      @(posedge CLOCK_50);
      din = {SW, ~KEY};
      if (!RESET_N) begin
        m_s1 = '0; m_s2 = '0; m_lvl = '0; m_rise = '0; m_fall = '0;
        m_tog = '0; m_long = '0;
        for (int k = 0; k < DEB; k++) m_hist[k] = '0;
        for (int k = 0; k < NK; k++) m_held[k] = 0;
      end else begin
        m_rise = '0; m_fall = '0;
        for (int c = 0; c < NC; c++) begin
          bit stable;
          stable = 1'b1;
          for (int k = 1; k < DEB; k++) if (m_hist[k][c] != m_hist[0][c]) stable = 1'b0;
          if (stable && m_hist[0][c] != m_lvl[c]) begin
            m_lvl[c]  = m_hist[0][c];
            m_rise[c] = m_lvl[c];
            m_fall[c] = ~m_lvl[c];
          end
        end
        for (int k = 0; k < NK; k++) begin
          m_tog[k] = m_tog[k] ^ m_rise[k];
          if (!m_lvl[k] || m_rise[k]) m_held[k] = 0;
          else                        m_held[k]++;
          m_long[k] = LONG_EN && m_lvl[k] && (m_held[k] == LP);
        end
        m_s2 = m_s1;
        m_s1 = din;
        for (int k = DEB-1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = m_s2;
      end
      #1;
      chk("key_level",   32'(key_level),   32'(m_lvl[NK-1:0]));
      chk("key_press",   32'(key_press),   32'(m_rise[NK-1:0]));
      chk("key_release", 32'(key_release), 32'(m_fall[NK-1:0]));
      chk("key_toggle",  32'(key_toggle),  32'(m_tog));
      chk("sw_level",    32'(sw_level),    32'(m_lvl[NC-1:NK]));
      chk("sw_change",   32'(sw_change),   32'(m_rise[NC-1:NK] | m_fall[NC-1:NK]));
      chk("key_long",    32'(key_long),    32'(m_long));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  initial begin
    RESET_N = 1'b0; KEY = 4'hF; SW = '0;
    step(3);
    chk("rst_key_level", 32'(key_level), 0);
    chk("rst_toggle",    32'(key_toggle), 0);
    chk("rst_sw_level",  32'(sw_level), 0);
    chk("rst_pulses",    32'({key_press, key_release, sw_change, key_long}), 0);
    RESET_N = 1'b1;
    step(2);

    // Clean press on KEY[0]
    KEY[0] = 1'b0;
    step(5);
    chk("press0_early", 32'(key_level[0]), 0);
    step(1);
    chk("press0_level", 32'(key_level[0]), 1);
    chk("press0_pulse", 32'(key_press[0]), 1);
    chk("press0_toggle", 32'(key_toggle[0]), 1);
    step(1);
    chk("press0_single", 32'(key_press[0]), 0);
    KEY[0] = 1'b1;
    step(10);

    // Glitch shorter than the window, then a real press on KEY[1]
    KEY[1] = 1'b0; step(3);
    KEY[1] = 1'b1; step(8);
    chk("glitch1_level", 32'(key_level[1]), 0);
    KEY[1] = 1'b0; step(6);
    chk("bounce1_press", 32'(key_press[1]), 1);
    step(4);
    KEY[1] = 1'b1; step(6);
    chk("bounce1_release", 32'(key_release[1]), 1);
    chk("bounce1_level",   32'(key_level[1]), 0);
    step(4);

    // Toggle sequence on KEY[2]
    chk("tog2_init", 32'(key_toggle[2]), 0);
    KEY[2] = 1'b0; step(10);
    chk("tog2_first", 32'(key_toggle[2]), 1);
    KEY[2] = 1'b1; step(10);
    KEY[2] = 1'b0; step(50);
    chk("tog2_second_held", 32'(key_toggle[2]), 0);
    KEY[2] = 1'b1; step(10);

    // All switches plus KEY[3] together
    SW = 10'h3FF; KEY[3] = 1'b0;
    step(6);
    chk("sim_sw_level",  32'(sw_level), 32'h3FF);
    chk("sim_sw_change", 32'(sw_change), 32'h3FF);
    chk("sim_key3",      32'(key_press[3]), 1);
    step(1);
    chk("sim_sw_change_off", 32'(sw_change), 0);
    SW = 10'h155; KEY[3] = 1'b1;
    step(6);
    chk("sw_partial_change", 32'(sw_change), 32'h2AA);
    step(4);

    // Reset in the middle of a KEY[0] debounce, key held through it
    KEY[0] = 1'b0;
    step(4);
    RESET_N = 1'b0; step(1);
    chk("midrst_toggle", 32'(key_toggle[0]), 0);
    RESET_N = 1'b1;
    step(5);
    chk("midrst_no_early", 32'(key_press[0]), 0);
    step(1);
    chk("midrst_press", 32'(key_press[0]), 1);
    step(16);
    chk("long0_pulse", 32'(key_long[0]), 32'(LONG_EN));
    step(1);
    chk("long0_single", 32'(key_long[0]), 0);
    step(14);
    KEY[0] = 1'b1; SW = '0;
    step(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
